// File: rtl/data_mem_responder_if.sv
// Request/response bus between a load/store initiator and data_mem_responder.
// The signal names match the original flat port list so that existing
// initiators can be attached field by field.
//   ReqValid/ReqReady  request handshake
//   Address/WriteData  word address and store data
//   MemWrite/MemRead   operation select (exactly one must be set)
//   RspValid/RspReady  response handshake
//   ReadData/RspErr    load data (0 for stores/errors) and reject flag
//   ByteEn             store byte lanes (only when DMEM_BYTE_MASK_EN is defined)
// Modports: master = initiator side, slave = responder side.
interface data_mem_responder_if;
  logic        ReqValid;
  logic        ReqReady;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic        RspValid;
  logic        RspReady;
  logic [31:0] ReadData;
  logic        RspErr;
`ifdef DMEM_BYTE_MASK_EN
  logic [3:0]  ByteEn;

  modport master (
    output ReqValid, Address, WriteData, MemWrite, MemRead, RspReady, ByteEn,
    input  ReqReady, RspValid, ReadData, RspErr
  );
  modport slave (
    input  ReqValid, Address, WriteData, MemWrite, MemRead, RspReady, ByteEn,
    output ReqReady, RspValid, ReadData, RspErr
  );
`else
  modport master (
    output ReqValid, Address, WriteData, MemWrite, MemRead, RspReady,
    input  ReqReady, RspValid, ReadData, RspErr
  );
  modport slave (
    input  ReqValid, Address, WriteData, MemWrite, MemRead, RspReady,
    output ReqReady, RspValid, ReadData, RspErr
  );
`endif
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: handshaked multi-cycle data memory target.
// Accepts one read or write at a time, waits LATENCY cycles, commits the
// access and presents a single response held until RspReady.
// Ports:
//   Clk      rising-edge clock
//   Reset_n  asynchronous active-low reset (memory contents are not reset)
//   bus      data_mem_responder_if.slave request/response bus
// Parameters: DEPTH words (power of two), ADDR_W = log2(DEPTH), LATENCY 0..15.
// Optional feature: define DMEM_BYTE_MASK_EN to add per-byte store enables
// (bus.ByteEn); otherwise every store writes the whole word.
module data_mem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input logic                 Clk,
  input logic                 Reset_n,
  data_mem_responder_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        re_q, re_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] read_data_q, read_data_d;
  logic        rsp_err_q, rsp_err_d;

  logic              accept;
  logic              rsp_hs;
  logic              commit;
  logic              mem_wr;
  logic [31:0]       c_addr;
  logic [31:0]       c_wdata;
  logic              c_we;
  logic              c_re;
  logic [3:0]        c_be;
  logic              c_err;
  logic [ADDR_W-1:0] c_idx;

  logic [31:0] mem [DEPTH];

`ifdef DMEM_BYTE_MASK_EN
  logic [3:0] be_q, be_d;
`endif

  // req_ready_q is only set in IDLE, so it alone qualifies the accept.
  assign accept = bus.ReqValid && req_ready_q;
  assign rsp_hs = rsp_valid_q && bus.RspReady;

  // Request latch: captured only on accept, so bus activity outside IDLE is ignored.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    re_d    = re_q;
`ifdef DMEM_BYTE_MASK_EN
    be_d    = be_q;
`endif
    if (accept) begin
      addr_d  = bus.Address;
      wdata_d = bus.WriteData;
      we_d    = bus.MemWrite;
      re_d    = bus.MemRead;
`ifdef DMEM_BYTE_MASK_EN
      be_d    = bus.ByteEn;
`endif
    end
  end

  // With LATENCY=0 the commit happens on the accept edge itself, before the
  // latch holds the request, so the operands come straight from the bus.
  always_comb begin
    if (state_q == ST_IDLE) begin
      c_addr  = bus.Address;
      c_wdata = bus.WriteData;
      c_we    = bus.MemWrite;
      c_re    = bus.MemRead;
`ifdef DMEM_BYTE_MASK_EN
      c_be    = bus.ByteEn;
`else
      c_be    = '1;
`endif
    end else begin
      c_addr  = addr_q;
      c_wdata = wdata_q;
      c_we    = we_q;
      c_re    = re_q;
`ifdef DMEM_BYTE_MASK_EN
      c_be    = be_q;
`else
      c_be    = '1;
`endif
    end
    c_idx = c_addr[ADDR_W-1:0];
    c_err = (c_we == c_re) || (c_addr[31:ADDR_W] != '0);
  end

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
`ifdef DMEM_BYTE_MASK_EN
      be_q        <= '0;
`endif
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      read_data_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      re_q        <= re_d;
`ifdef DMEM_BYTE_MASK_EN
      be_q        <= be_d;
`endif
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      read_data_q <= read_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state logic; the wait counter counts 1..LATENCY inside WAIT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (LAT == 4'd0) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'd1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == LAT) begin
          state_d = ST_RESP;
          cnt_d   = '0;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs follow the next state, so ReqReady stays low while
  // reset is held and rises on the first edge after release.
  always_comb begin
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    read_data_d = read_data_q;
    rsp_err_d   = rsp_err_q;
    mem_wr      = commit && c_we && !c_err;
    if (commit) begin
      rsp_err_d   = c_err;
      read_data_d = (c_re && !c_err) ? mem[c_idx] : '0;
    end else if (rsp_hs) begin
      read_data_d = '0;
      rsp_err_d   = 1'b0;
    end
  end

  // Memory array: deliberately not reset so contents survive Reset_n.
  always_ff @(posedge Clk) begin
    if (mem_wr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (c_be[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end

  assign bus.ReqReady = req_ready_q;
  assign bus.RspValid = rsp_valid_q;
  assign bus.ReadData = read_data_q;
  assign bus.RspErr   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] ref_mem [1024];

  always #5 clk = ~clk;

  data_mem_responder_if b0 ();
  data_mem_responder_if b1 ();

  data_mem_responder #(.DEPTH(1024), .ADDR_W(10), .LATENCY(2)) dut0 (
    .Clk(clk), .Reset_n(rst_n), .bus(b0.slave)
  );

  data_mem_responder #(.DEPTH(1024), .ADDR_W(10), .LATENCY(0)) dut1 (
    .Clk(clk), .Reset_n(rst_n), .bus(b1.slave)
  );

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: rule-based error check, word array with byte lanes.
  function automatic void model(input logic we, input logic re, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [3:0] be,
                                output logic [31:0] rd, output logic err);
    logic [3:0] m;
    err = (we == re) || ((addr >> 10) != 0);
    rd  = 32'd0;
`ifdef DMEM_BYTE_MASK_EN
    m = be;
`else
    m = 4'hF;
`endif
    if (!err && re) rd = ref_mem[addr % 1024];
    if (!err && we)
      for (int b = 0; b < 4; b++)
        if (m[b]) ref_mem[addr % 1024][8*b +: 8] = wd[8*b +: 8];
  endfunction

  task automatic scramble0();
    b0.Address   = $urandom;
    b0.WriteData = $urandom;
    b0.MemWrite  = 1'($urandom);
    b0.MemRead   = 1'($urandom);
`ifdef DMEM_BYTE_MASK_EN
    b0.ByteEn    = 4'($urandom);
`endif
  endtask

  // Called and returns at a negedge. Request stays asserted with garbage
  // fields while the responder is busy; hold = cycles of RspReady=0 backpressure.
  task automatic txn(input logic we, input logic re, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] be,
                     input int unsigned hold, input string tag);
    logic [31:0] exp_rd, rd0;
    logic        exp_err, err0;
    int unsigned n;
    model(we, re, addr, wd, be, exp_rd, exp_err);
    b0.ReqValid = 1'b1; b0.Address = addr; b0.WriteData = wd;
    b0.MemWrite = we;   b0.MemRead = re;
`ifdef DMEM_BYTE_MASK_EN
    b0.ByteEn = be;
`endif
    n = 0;
    while (b0.ReqReady !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_accept_timeout"}, 32'(n < 20), 32'd1);
    @(negedge clk);
    scramble0();
    n = 1;
    while (b0.RspValid !== 1'b1 && n < 20) begin @(negedge clk); n++; scramble0(); end
    chk({tag, "_latency"}, n, 32'd3);
    rd0 = b0.ReadData; err0 = b0.RspErr;
    chk({tag, "_rdata"}, rd0, exp_rd);
    chk({tag, "_err"}, 32'(err0), 32'(exp_err));
    for (int k = 0; k < int'(hold); k++) begin
      @(negedge clk);
      scramble0();
      chk({tag, "_bp_valid"}, 32'(b0.RspValid), 32'd1);
      chk({tag, "_bp_reqready"}, 32'(b0.ReqReady), 32'd0);
      chk({tag, "_bp_rdata"}, b0.ReadData, rd0);
      chk({tag, "_bp_err"}, 32'(b0.RspErr), 32'(err0));
    end
    b0.RspReady = 1'b1; b0.ReqValid = 1'b0;
    @(negedge clk);
    b0.RspReady = 1'b0;
    chk({tag, "_post_valid"}, 32'(b0.RspValid), 32'd0);
    chk({tag, "_post_rdata"}, b0.ReadData, 32'd0);
    chk({tag, "_post_err"}, 32'(b0.RspErr), 32'd0);
    chk({tag, "_post_reqready"}, 32'(b0.ReqReady), 32'd1);
  endtask

  // Zero-latency instance: response expected right after the accept edge.
  task automatic txn_l0(input logic we, input logic re, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input string tag);
    b1.ReqValid = 1'b1; b1.Address = addr; b1.WriteData = wd;
    b1.MemWrite = we;   b1.MemRead = re;
    chk({tag, "_reqready"}, 32'(b1.ReqReady), 32'd1);
    @(negedge clk);
    b1.ReqValid = 1'b0;
    chk({tag, "_valid"}, 32'(b1.RspValid), 32'd1);
    chk({tag, "_rdata"}, b1.ReadData, exp_rd);
    chk({tag, "_err"}, 32'(b1.RspErr), 32'd0);
    b1.RspReady = 1'b1;
    @(negedge clk);
    b1.RspReady = 1'b0;
    chk({tag, "_post_valid"}, 32'(b1.RspValid), 32'd0);
  endtask

  initial begin
    logic [31:0] v, a;
    logic        we, re;
    rst_n = 1'b0;
    b0.ReqValid = 1'b0; b0.RspReady = 1'b0; b0.Address = '0; b0.WriteData = '0;
    b0.MemWrite = 1'b0; b0.MemRead = 1'b0;
    b1.ReqValid = 1'b0; b1.RspReady = 1'b0; b1.Address = '0; b1.WriteData = '0;
    b1.MemWrite = 1'b0; b1.MemRead = 1'b0;
`ifdef DMEM_BYTE_MASK_EN
    b0.ByteEn = 4'hF; b1.ByteEn = 4'hF;
`endif

    // Reset state, including ReqReady low while reset is held.
    @(negedge clk); @(negedge clk);
    chk("rst_reqready", 32'(b0.ReqReady), 32'd0);
    chk("rst_valid", 32'(b0.RspValid), 32'd0);
    chk("rst_rdata", b0.ReadData, 32'd0);
    chk("rst_err", 32'(b0.RspErr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_reqready", 32'(b0.ReqReady), 32'd1);

    // Preload a known window so every later load has a defined expectation.
    for (int i = 0; i < 64; i++) txn(1'b1, 1'b0, 32'(i), $urandom, 4'hF, 0, "pre");

    // T1 store/load
    txn(1, 0, 10, 653, 4'hF, 0, "t1_st10");
    txn(1, 0, 11, 221, 4'hF, 1, "t1_st11");
    txn(1, 0, 12, 421, 4'hF, 0, "t1_st12");
    txn(1, 0, 13, 1343, 4'hF, 2, "t1_st13");
    txn(1, 0, 14, 5531, 4'hF, 0, "t1_st14");
    txn(1, 0, 781, 741, 4'hF, 0, "t1_st781");
    txn(0, 1, 10, 0, 4'hF, 0, "t1_ld10");
    txn(0, 1, 11, 0, 4'hF, 0, "t1_ld11");
    txn(0, 1, 12, 0, 4'hF, 0, "t1_ld12");
    txn(0, 1, 13, 0, 4'hF, 0, "t1_ld13");
    txn(0, 1, 14, 0, 4'hF, 0, "t1_ld14");
    txn(0, 1, 781, 0, 4'hF, 0, "t1_ld781");

    // T2 backpressure
    txn(0, 1, 10, 0, 4'hF, 5, "t2_bp");

    // T3 errors
    txn(1, 0, 20, 0, 4'hF, 0, "t3_clr20");
    txn(1, 1, 20, 99, 4'hF, 0, "t3_both");
    txn(0, 1, 20, 0, 4'hF, 0, "t3_ld20");
    txn(0, 0, 21, 5, 4'hF, 0, "t3_none");
    txn(1, 0, 1024, 123, 4'hF, 0, "t3_oob");
    txn(0, 1, 0, 0, 4'hF, 0, "t3_ld0");
    txn(0, 1, 32'h8000_0005, 0, 4'hF, 0, "t3_oob_ld");

    // T4 reset during WAIT of a store
    b0.ReqValid = 1'b1; b0.Address = 30; b0.WriteData = 77;
    b0.MemWrite = 1'b1; b0.MemRead = 1'b0;
    chk("t4_reqready", 32'(b0.ReqReady), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t4_reqready_rst", 32'(b0.ReqReady), 32'd0);
    chk("t4_valid_rst", 32'(b0.RspValid), 32'd0);
    chk("t4_rdata_rst", b0.ReadData, 32'd0);
    chk("t4_err_rst", 32'(b0.RspErr), 32'd0);
    b0.ReqValid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t4_held_reqready", 32'(b0.ReqReady), 32'd0);
      chk("t4_held_valid", 32'(b0.RspValid), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("t4_rel_reqready", 32'(b0.ReqReady), 32'd1);
    txn(0, 1, 30, 0, 4'hF, 0, "t4_ld30");

    // T5 zero-latency instance
    v = $urandom;
    txn_l0(1, 0, 100, v, 0, "t5_st");
    txn_l0(0, 1, 100, 0, v, "t5_ld");

`ifdef DMEM_BYTE_MASK_EN
    // T6 byte enables
    txn(1, 0, 5, 32'hAABBCCDD, 4'hF, 0, "t6_full");
    txn(1, 0, 5, 32'h11223344, 4'b0101, 0, "t6_part");
    txn(1, 0, 5, 32'h55667788, 4'b0000, 0, "t6_none");
    txn(0, 1, 5, 0, 4'hF, 0, "t6_ld5");
    chk("t6_model", ref_mem[5], 32'hAA22CC44);
`endif

    // Randomized mix against the reference model.
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom); re = 1'($urandom);
      if ($urandom_range(0, 7) == 0) a = 32'h400 + $urandom_range(0, 4095);
      else a = $urandom_range(0, 63);
      txn(we, re, a, $urandom, 4'($urandom), $urandom_range(0, 3), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
